md_unit_param: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the MiniSys-1A execute stage.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles using a start/busy/done handshake; MTHI/MTLO write in a single cycle.
- The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

---
 rtl/md_unit_param.sv | 192 +++++++++++++++++++
 tb/tb_md_unit_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_param.sv
// md_unit_param: iterative multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU take WIDTH+2 cycles (divide-by-zero: 2 cycles)
// through IDLE -> PREP -> CALC -> FIX. MTHI/MTLO write in a single cycle.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start, md_op    op request and opcode; accepted only while ready
//   src_a, src_b    operands (src_a is also the MTHI/MTLO data)
//   flush           abort the in-flight op without touching hi/lo/div_zero
//   ready           combinational ~busy
//   busy, done      multi-cycle op in flight; one-cycle result pulse
//   div_zero        last DIV/DIVU had a zero divisor
//   hi, lo          HI/LO registers
module md_unit_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned W2    = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

   state_t             state_q, state_nx;
   logic [WIDTH-1:0]   a_q, a_nx, b_q, b_nx;
   logic [W2-1:0]      acc_q, acc_nx;
   logic [CNT_W-1:0]   cnt_q, cnt_nx;
   logic               is_div_q, is_div_nx, uns_q, uns_nx;
   logic               neg_res_q, neg_res_nx, neg_rem_q, neg_rem_nx;
   logic               dz_q, dz_nx;
   logic [WIDTH-1:0]   hi_nx, lo_nx;
   logic               busy_nx, done_nx, div_zero_nx;

   // Datapath helpers for one CALC step and the FIX sign correction
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0]   rem_new, quo_fix, rem_fix;
   logic [W2-1:0]      prod_fix;
   logic               div_ok;

   assign ready = ~busy;

   // Shift-add: the high half accumulates, the low half collects retired product bits
   assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
   // Restoring divide: dividend bits enter the remainder MSB-first from a_q
   assign div_shift = {acc_q[W2-1:WIDTH], a_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, b_q};
   assign div_ok    = ~div_trial[WIDTH];
   assign rem_new   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

   assign prod_fix  = neg_res_q ? -acc_q : acc_q;
   assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix   = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         uns_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         state_q   <= state_nx;
         a_q       <= a_nx;
         b_q       <= b_nx;
         acc_q     <= acc_nx;
         cnt_q     <= cnt_nx;
         is_div_q  <= is_div_nx;
         uns_q     <= uns_nx;
         neg_res_q <= neg_res_nx;
         neg_rem_q <= neg_rem_nx;
         dz_q      <= dz_nx;
         hi        <= hi_nx;
         lo        <= lo_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         div_zero  <= div_zero_nx;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx    = state_q;
      a_nx        = a_q;
      b_nx        = b_q;
      acc_nx      = acc_q;
      cnt_nx      = cnt_q;
      is_div_nx   = is_div_q;
      uns_nx      = uns_q;
      neg_res_nx  = neg_res_q;
      neg_rem_nx  = neg_rem_q;
      dz_nx       = dz_q;
      hi_nx       = hi;
      lo_nx       = lo;
      busy_nx     = busy;
      done_nx     = 1'b0;
      div_zero_nx = div_zero;

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               if (!md_op[2]) begin
                  is_div_nx = md_op[1];
                  uns_nx    = md_op[0];
                  a_nx      = src_a;
                  b_nx      = src_b;
                  busy_nx   = 1'b1;
                  state_nx  = S_PREP;
               end else if (!md_op[1]) begin
                  if (md_op[0]) lo_nx = src_a;
                  else          hi_nx = src_a;
               end
            end
         end
         S_PREP: begin
            dz_nx      = is_div_q && (b_q == '0);
            neg_res_nx = !uns_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem_nx = !uns_q && a_q[WIDTH-1];
            // A zero divisor keeps a_q raw so hi can return the dividend unmodified
            if (!uns_q && !dz_nx) begin
               a_nx = a_q[WIDTH-1] ? -a_q : a_q;
               b_nx = b_q[WIDTH-1] ? -b_q : b_q;
            end
            cnt_nx   = CNT_W'(WIDTH);
            acc_nx   = '0;
            state_nx = dz_nx ? S_FIX : S_CALC;
         end
         S_CALC: begin
            cnt_nx = cnt_q - CNT_W'(1);
            if (is_div_q) begin
               acc_nx = {rem_new, acc_q[WIDTH-2:0], div_ok};
               a_nx   = {a_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_nx = {mul_sum, acc_q[WIDTH-1:1]};
               b_nx   = {1'b0, b_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_W'(1)) state_nx = S_FIX;
         end
         S_FIX: begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            if (is_div_q) begin
               div_zero_nx = dz_q;
               if (dz_q) begin
                  lo_nx = '1;
                  hi_nx = a_q;
               end else begin
                  lo_nx = quo_fix;
                  hi_nx = rem_fix;
               end
            end else begin
               {hi_nx, lo_nx} = prod_fix;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Squash wins over everything, including a FIX write
      if (flush && (state_q != S_IDLE)) begin
         state_nx    = S_IDLE;
         busy_nx     = 1'b0;
         done_nx     = 1'b0;
         hi_nx       = hi;
         lo_nx       = lo;
         div_zero_nx = div_zero;
      end
   end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a 32-bit and an 8-bit instance. Expected
// results are queued when an op is issued and popped when done is seen.
module tb_md_unit_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, flush, ready, busy, done, div_zero;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b, hi, lo;

   logic        s8_start, s8_flush, s8_ready, s8_busy, s8_done, s8_div_zero;
   logic [2:0]  s8_op;
   logic [7:0]  s8_a, s8_b, s8_hi, s8_lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;
   exp_t sb[$];

   localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                          OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

   always #5 clk = ~clk;

   md_unit_param #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .src_a(src_a),
      .src_b(src_b), .flush(flush), .ready(ready), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo));

   md_unit_param #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(s8_start), .md_op(s8_op), .src_a(s8_a),
      .src_b(s8_b), .flush(s8_flush), .ready(s8_ready), .busy(s8_busy), .done(s8_done),
      .div_zero(s8_div_zero), .hi(s8_hi), .lo(s8_lo));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the start edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_res(input logic [31:0] eh, input logic [31:0] el,
                             input logic edz, input int lat);
      exp_t e;
      e.hi = eh; e.lo = el; e.dz = edz; e.lat = lat;
      sb.push_back(e);
   endtask

   // Waits for done (bounded), then compares against the oldest queued result
   task automatic wait_done(input string tag, input int cyc0);
      int   cyc;
      exp_t e;
      cyc = cyc0;
      while (done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (sb.size() != 0) e = sb.pop_front();
      else begin
         e.hi = 'x; e.lo = 'x; e.dz = 1'bx; e.lat = -1;
      end
      chk({tag, " done"}, 64'(done), 64'(1));
      chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
      chk({tag, " hi"}, 64'(hi), 64'(e.hi));
      chk({tag, " lo"}, 64'(lo), 64'(e.lo));
      chk({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
      chk({tag, " busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int   cyc;
      logic seen;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = '0; src_a = '0; src_b = '0;
      s8_start = 1'b0; s8_flush = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset hi", 64'(hi), 64'(0));
      chk("reset lo", 64'(lo), 64'(0));
      chk("reset busy/done/dz", 64'({busy, done, div_zero}), 64'(0));
      chk("reset ready", 64'(ready), 64'(1));
      rst_n = 1'b1;
      @(negedge clk);

      // Single-cycle moves
      issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
      chk("mthi hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
      chk("mthi busy", 64'({busy, done}), 64'(0));
      issue(OP_MTLO, 32'h12345678, 32'h0);
      chk("mtlo lo", 64'(lo), 64'h0000_0000_1234_5678);
      chk("mtlo hi kept", 64'(hi), 64'h0000_0000_DEAD_BEEF);
      chk("mtlo busy", 64'({busy, done}), 64'(0));

      // Multiply / divide results
      expect_res(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 34);
      issue(OP_MULT, 32'hFFFFFFFE, 32'h3);
      chk("mult busy after start", 64'({busy, ready}), 64'(2));
      wait_done("mult", 0);
      @(negedge clk);
      chk("done one cycle", 64'(done), 64'(0));
      expect_res(32'h2, 32'hFFFFFFFA, 1'b0, 34);
      issue(OP_MULTU, 32'hFFFFFFFE, 32'h3);
      wait_done("multu", 0);
      expect_res(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
      wait_done("div -7/2", 0);
      expect_res(32'd2, 32'd14, 1'b0, 34);
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done("divu 100/7", 0);
      expect_res(32'h0, 32'h80000000, 1'b0, 34);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div overflow", 0);
      expect_res(32'd5, 32'hFFFFFFFF, 1'b1, 2);
      issue(OP_DIVU, 32'd5, 32'd0);
      wait_done("divu by zero", 0);
      // Issued in the done cycle: must be accepted immediately
      expect_res(32'd0, 32'd2, 1'b0, 34);
      issue(OP_DIVU, 32'd6, 32'd3);
      wait_done("divu back-to-back", 0);

      // start/MTLO while busy are ignored
      expect_res(32'd0, 32'd15, 1'b0, 34);
      issue(OP_MULTU, 32'd3, 32'd5);
      repeat (3) @(negedge clk);
      start = 1'b1; md_op = OP_MTLO; src_a = 32'hAAAA5555;
      @(negedge clk);
      start = 1'b0;
      wait_done("start while busy", 4);

      // Flush mid-CALC: no done, hi/lo untouched
      issue(OP_MULT, 32'd7, 32'd7);
      repeat (10) @(negedge clk);
      chk("pre-flush busy", 64'(busy), 64'(1));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", 64'({busy, done}), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen = seen | done | busy;
      end
      chk("flush no done", 64'(seen), 64'(0));
      chk("flush hi kept", 64'(hi), 64'(0));
      chk("flush lo kept", 64'(lo), 64'(15));

      // Flush in IDLE blocks a same-cycle start
      flush = 1'b1;
      issue(OP_MTHI, 32'h77, 32'h0);
      flush = 1'b0;
      chk("idle flush blocks mthi", 64'(hi), 64'(0));
      issue(OP_MULT, 32'h5, 32'h5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush in PREP", 64'({busy, done}), 64'(0));

      // 8-bit instance
      s8_start = 1'b1; s8_op = OP_MULTU; s8_a = 8'hFF; s8_b = 8'hFF;
      @(negedge clk);
      s8_start = 1'b0;
      cyc = 0;
      while (s8_done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("w8 latency", 64'(cyc), 64'(10));
      chk("w8 hi", 64'(s8_hi), 64'hFE);
      chk("w8 lo", 64'(s8_lo), 64'h01);

      // Async reset mid-CALC, checked between clock edges
      s8_start = 1'b1; s8_op = OP_MULTU; s8_a = 8'h12; s8_b = 8'h34;
      @(negedge clk);
      s8_start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst w8 hi/lo", 64'({s8_hi, s8_lo}), 64'(0));
      chk("async rst w8 busy", 64'(s8_busy), 64'(0));
      chk("async rst w32 lo", 64'(lo), 64'(0));
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("after rst w8 idle", 64'({s8_busy, s8_done}), 64'(0));
      chk("scoreboard drained", 64'(sb.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
